alu_share_ctrl: RTL and testbench

//  Shares one 64-bit combinational ALU (a, b, 5-bit sel -> 128-bit c) among NUM_REQ requesters.

---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/alu_share_ctrl_rr_arbiter.sv | 36 +++
 rtl/alu_share_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 579 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Opcode constants and controller state encoding shared by alu_share_ctrl and its bench.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4;
    localparam logic [4:0] OP_MAX = 5'd21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

    // Div and mod are the only ops that cannot accept a zero right operand.
    function automatic logic op_needs_divisor(input logic [4:0] sel);
        return (sel == OP_DIV) || (sel == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic             hit_s;
    logic [IDX_W-1:0] pos_s;

    function automatic int wrap_pos(input int p, input int o);
        return (p + o) % N;
    endfunction

    // Scan requesters starting from the pointer; the first hit wins.
    always_comb begin
        grant = {N{1'b0}};
        idx   = {IDX_W{1'b0}};
        any   = 1'b0;
        hit_s = 1'b0;
        pos_s = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            pos_s        = IDX_W'(wrap_pos(int'(ptr), i));
            hit_s        = ~any & req[pos_s];
            grant[pos_s] = hit_s;
            idx          = hit_s ? pos_s : idx;
            any          = any | hit_s;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU among NUM_REQ requesters with round-robin
// arbitration, a fixed settle window per op and a valid/ready response channel.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 64,
    parameter int SEL_W       = 5,
    parameter int EXEC_CYCLES = 2,
    parameter int MAX_OP      = 21
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*DATA_W-1:0]        rsp_result,
    output logic                       rsp_illegal,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [SEL_W-1:0]           alu_sel,
    input  logic [2*DATA_W-1:0]        alu_c,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(MAX_OP);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    ctrl_state_e         state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]    rsp_id_q, rsp_id_d;
    logic [2*DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic                rsp_illegal_q, rsp_illegal_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  arb_grant_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic                arb_any_s;
    logic [NUM_REQ-1:0]  req_ready_s;
    logic [DATA_W-1:0]   win_a_s;
    logic [DATA_W-1:0]   win_b_s;
    logic [SEL_W-1:0]    win_sel_s;
    logic                reject_s;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    // Select the winner's operands (grant is one-hot) and classify the op.
    always_comb begin
        win_a_s   = {DATA_W{1'b0}};
        win_b_s   = {DATA_W{1'b0}};
        win_sel_s = {SEL_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            win_a_s   = arb_grant_s[i] ? req_a[i*DATA_W +: DATA_W] : win_a_s;
            win_b_s   = arb_grant_s[i] ? req_b[i*DATA_W +: DATA_W] : win_b_s;
            win_sel_s = arb_grant_s[i] ? req_sel[i*SEL_W +: SEL_W] : win_sel_s;
        end
        reject_s = (win_sel_s > SEL_MAX) ||
                   (op_needs_divisor(5'(win_sel_s)) && (win_b_s == {DATA_W{1'b0}}));
    end

    // Next-state and datapath update for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_illegal_d = rsp_illegal_q;
        req_ready_s   = {NUM_REQ{1'b0}};

        case (state_q)
            IDLE: begin
                if (arb_any_s && !rst) begin
                    req_ready_s = arb_grant_s;
                    ptr_d       = (arb_idx_s == IDX_LAST) ? {IDX_W{1'b0}} : arb_idx_s + IDX_W'(1);
                    rsp_id_d    = arb_idx_s;
                    if (reject_s) begin
                        // Rejected ops skip the ALU entirely and leave alu_* untouched.
                        rsp_illegal_d = 1'b1;
                        rsp_result_d  = {(2*DATA_W){1'b0}};
                        rsp_valid_d   = 1'b1;
                        state_d       = RESP;
                    end else begin
                        rsp_illegal_d = 1'b0;
                        alu_a_d       = win_a_s;
                        alu_b_d       = win_b_s;
                        alu_sel_d     = win_sel_s;
                        cnt_d         = CNT_LOAD;
                        state_d       = EXEC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    rsp_result_d = alu_c;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= {IDX_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            alu_a_q       <= {DATA_W{1'b0}};
            alu_b_q       <= {DATA_W{1'b0}};
            alu_sel_q     <= {SEL_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= {IDX_W{1'b0}};
            rsp_result_q  <= {(2*DATA_W){1'b0}};
            rsp_illegal_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_illegal_q <= rsp_illegal_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready   = req_ready_s;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_illegal = rsp_illegal_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU on the alu_* port.
module tb_alu_share_ctrl;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SW = 5;
    localparam int EC = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic [N*SW-1:0]   req_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [2*DW-1:0]   rsp_result;
    logic              rsp_illegal;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [SW-1:0]     alu_sel;
    logic [2*DW-1:0]   alu_c;
    logic              busy;

    logic [DW-1:0] ta [N];
    logic [DW-1:0] tb [N];
    logic [SW-1:0] ts [N];

    typedef struct {
        logic [1:0]      id;
        logic [2*DW-1:0] res;
        logic            ill;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int          mon_gi;
    logic [63:0] mon_a, mon_b;
    logic [4:0]  mon_s;
    exp_t        mon_e, mon_p;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a[g*DW +: DW]  = ta[g];
        assign req_b[g*DW +: DW]  = tb[g];
        assign req_sel[g*SW +: SW] = ts[g];
    end

    function automatic logic [127:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                               input logic [4:0] s);
        case (s)
            5'd0:    return {64'd0, a} + {64'd0, b};
            5'd1:    return {64'd0, a - b};
            5'd2:    return {64'd0, a} * {64'd0, b};
            5'd3:    return (b == 64'd0) ? 128'd0 : {64'd0, a / b};
            5'd4:    return (b == 64'd0) ? 128'd0 : {64'd0, a % b};
            default: return {64'd0, a ^ b};
        endcase
    endfunction

    assign alu_c = alu_model(alu_a, alu_b, alu_sel);

    alu_share_ctrl #(
        .NUM_REQ(N), .DATA_W(DW), .SEL_W(SW), .EXEC_CYCLES(EC), .MAX_OP(21)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_illegal(rsp_illegal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard: push on every grant, pop and compare on every response handshake.
    always begin
        @(negedge clk);
        #3;
        if (!rst && req_ready != 4'b0000) begin
            n_checks++;
            if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != 4'b0000) begin
                n_fail++;
                $display("FAIL grant_onehot got=%b valid=%b", req_ready, req_valid);
            end
            mon_gi = 0;
            for (int k = 0; k < N; k++) if (req_ready[k]) mon_gi = k;
            mon_a = ta[mon_gi];
            mon_b = tb[mon_gi];
            mon_s = ts[mon_gi];
            mon_e.id = 2'(mon_gi);
            if (mon_s > 5'd21 || ((mon_s == 5'd3 || mon_s == 5'd4) && mon_b == 64'd0)) begin
                mon_e.res = 128'd0;
                mon_e.ill = 1'b1;
            end else begin
                mon_e.res = alu_model(mon_a, mon_b, mon_s);
                mon_e.ill = 1'b0;
            end
            sb_q.push_back(mon_e);
            grant_log.push_back(mon_gi);
            grant_cyc.push_back(cyc);
        end
        if (!rst && rsp_valid && rsp_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected id=%0d result=%h", rsp_id, rsp_result);
            end else begin
                mon_p = sb_q.pop_front();
                if (rsp_id !== mon_p.id || rsp_result !== mon_p.res || rsp_illegal !== mon_p.ill) begin
                    n_fail++;
                    $display("FAIL rsp_data got id=%0d res=%h ill=%b exp id=%0d res=%h ill=%b",
                             rsp_id, rsp_result, rsp_illegal, mon_p.id, mon_p.res, mon_p.ill);
                end
            end
        end
    end

    task automatic set_req(input logic [1:0] i, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] s);
        ta[i] = a;
        tb[i] = b;
        ts[i] = s;
        req_valid[i] = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        sb_q.delete();
        grant_log.delete();
        grant_cyc.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #4;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl busy=%b rsp_valid=%b req_ready=%b exp 0", busy, rsp_valid, req_ready);
        end
        n_checks++;
        if (rsp_id !== 2'd0 || rsp_result !== 128'd0 || rsp_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp id=%0d res=%h ill=%b exp 0", rsp_id, rsp_result, rsp_illegal);
        end
        n_checks++;
        if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_sel !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_alu a=%h b=%h sel=%h exp 0", alu_a, alu_b, alu_sel);
        end
    endtask

    task automatic test_single();
        int  t;
        bit  seen;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(2'd0, 64'd100, 64'd50, 5'd0);
        #4;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant got=%b exp=0001", req_ready);
        end
        t = cyc;
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        n_checks++;
        if (busy !== 1'b1 || alu_a !== 64'd100 || alu_b !== 64'd50 || alu_sel !== 5'd0) begin
            n_fail++;
            $display("FAIL single_exec busy=%b a=%0d b=%0d sel=%0d exp 1/100/50/0", busy, alu_a, alu_b, alu_sel);
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #4;
        end
        n_checks++;
        if (!seen || cyc != t + EC + 1) begin
            n_fail++;
            $display("FAIL single_latency got=%0d exp=%0d seen=%b", cyc - t, EC + 1, seen);
        end
        n_checks++;
        if (rsp_id !== 2'd0 || rsp_result !== 128'd150 || rsp_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp id=%0d res=%0d ill=%b exp 0/150/0", rsp_id, rsp_result, rsp_illegal);
        end
        @(negedge clk);
        #4;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done rsp_valid=%b busy=%b exp 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_fairness();
        test_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(2'(i), 64'(i * 10 + 1), 64'(i + 1), 5'd0);
        #4;
        for (int k = 0; k < 60 && grant_log.size() < 6; k++) begin
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        n_checks++;
        if (grant_log.size() != 6) begin
            n_fail++;
            $display("FAIL fair_count got=%0d exp=6", grant_log.size());
        end
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            n_checks++;
            if (grant_log[k] != k % N) begin
                n_fail++;
                $display("FAIL fair_order[%0d] got=%0d exp=%0d", k, grant_log[k], k % N);
            end
        end
        for (int k = 1; k < 6 && k < grant_cyc.size(); k++) begin
            n_checks++;
            if (grant_cyc[k] - grant_cyc[k-1] != EC + 2) begin
                n_fail++;
                $display("FAIL fair_spacing[%0d] got=%0d exp=%0d", k, grant_cyc[k] - grant_cyc[k-1], EC + 2);
            end
        end
        for (int k = 0; k < 20 && (busy || sb_q.size() != 0); k++) begin
            @(negedge clk);
            #4;
        end
        n_checks++;
        if (busy !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL fair_drain busy=%b pending=%0d exp 0/0", busy, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(2'd1, 64'd1000, 64'd1, 5'd1);
        #4;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_grant got=%b exp=0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        set_req(2'd2, 64'd5, 64'd5, 5'd0);
        #4;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #4;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL bp_wait got=no response exp=response");
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 128'd999 ||
                rsp_illegal !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] v=%b id=%0d res=%0d ill=%b rdy=%b busy=%b exp 1/1/999/0/0000/1",
                         k, rsp_valid, rsp_id, rsp_result, rsp_illegal, req_ready, busy);
            end
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        #4;
        @(negedge clk);
        #4;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_reject();
        int t;
        bit seen;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(2'd2, 64'd7, 64'd7, 5'b11000);
        #4;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rej_sel_grant got=%b exp=0100", req_ready);
        end
        t = cyc;
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        n_checks++;
        if (rsp_valid !== 1'b1 || cyc != t + 1 || rsp_illegal !== 1'b1 || rsp_result !== 128'd0) begin
            n_fail++;
            $display("FAIL rej_sel_rsp v=%b lat=%0d ill=%b res=%h exp 1/1/1/0", rsp_valid, cyc - t, rsp_illegal, rsp_result);
        end
        n_checks++;
        if (alu_a !== 64'd1000 || alu_b !== 64'd1 || alu_sel !== 5'd1) begin
            n_fail++;
            $display("FAIL rej_sel_alu a=%0d b=%0d sel=%0d exp 1000/1/1", alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        set_req(2'd3, 64'd500, 64'd0, 5'd4);
        #4;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL rej_mod_grant got=%b exp=1000", req_ready);
        end
        t = cyc;
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        n_checks++;
        if (rsp_valid !== 1'b1 || cyc != t + 1 || rsp_illegal !== 1'b1 || rsp_result !== 128'd0 ||
            alu_a !== 64'd1000 || alu_b !== 64'd1 || alu_sel !== 5'd1) begin
            n_fail++;
            $display("FAIL rej_mod_rsp v=%b lat=%0d ill=%b res=%h a=%0d b=%0d sel=%0d exp 1/1/1/0/1000/1/1",
                     rsp_valid, cyc - t, rsp_illegal, rsp_result, alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        set_req(2'd0, 64'd500, 64'd7, 5'd3);
        set_req(2'd1, 64'd500, 64'd7, 5'd4);
        #4;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL divmod_grant got=%b exp=0001", req_ready);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        #4;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (req_ready[1]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #4;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL divmod_second got=no grant exp=grant to 1");
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        for (int k = 0; k < 20 && (busy || sb_q.size() != 0); k++) begin
            @(negedge clk);
            #4;
        end
        n_checks++;
        if (busy !== 1'b0 || sb_q.size() != 0 || alu_sel !== 5'd4 || alu_b !== 64'd7) begin
            n_fail++;
            $display("FAIL divmod_drain busy=%b pending=%0d sel=%0d b=%0d exp 0/0/4/7", busy, sb_q.size(), alu_sel, alu_b);
        end
    endtask

    task automatic test_wrap_mul();
        int t;
        bit seen;
        test_reset();
        @(negedge clk);
        set_req(2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2);
        #4;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL mul_grant got=%b exp=1000", req_ready);
        end
        t = cyc;
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #4;
        end
        n_checks++;
        if (!seen || cyc != t + EC + 1 || rsp_id !== 2'd3 ||
            rsp_result !== 128'h1_FFFF_FFFF_FFFF_FFFE || rsp_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_rsp lat=%0d id=%0d res=%h ill=%b exp %0d/3/1fffffffffffffffe/0",
                     cyc - t, rsp_id, rsp_result, rsp_illegal, EC + 1);
        end
        @(negedge clk);
        set_req(2'd0, 64'd1, 64'd1, 5'd0);
        set_req(2'd3, 64'd2, 64'd2, 5'd0);
        #4;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_to0 got=%b exp=0001", req_ready);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        #4;
        for (int k = 0; k < 20 && !req_ready[3]; k++) begin
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        for (int k = 0; k < 20 && (busy || sb_q.size() != 0); k++) begin
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        set_req(2'd1, 64'd9, 64'd4, 5'd1);
        #4;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_req1 got=%b exp=0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        for (int k = 0; k < 20 && (busy || sb_q.size() != 0); k++) begin
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        set_req(2'd0, 64'd3, 64'd3, 5'd0);
        set_req(2'd3, 64'd4, 64'd4, 5'd0);
        #4;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_to3 got=%b exp=1000", req_ready);
        end
        @(negedge clk);
        req_valid[3] = 1'b0;
        #4;
        for (int k = 0; k < 20 && !req_ready[0]; k++) begin
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        for (int k = 0; k < 20 && (busy || sb_q.size() != 0); k++) begin
            @(negedge clk);
            #4;
        end
        n_checks++;
        if (busy !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_drain busy=%b pending=%0d exp 0/0", busy, sb_q.size());
        end
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(2'd2, 64'd11, 64'd22, 5'd0);
        #4;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstx_grant got=%b exp=0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b1;
        sb_q.delete();
        #4;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstx_exec busy=%b exp=1", busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #4;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_sel !== 5'd0) begin
            n_fail++;
            $display("FAIL rstx_clear busy=%b v=%b a=%h b=%h sel=%h exp all 0", busy, rsp_valid, alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        set_req(2'd1, 64'd6, 64'd7, 5'd0);
        set_req(2'd3, 64'd8, 64'd9, 5'd0);
        #4;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstx_ptr got=%b exp=0010", req_ready);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        #4;
        for (int k = 0; k < 20 && !req_ready[3]; k++) begin
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #4;
        for (int k = 0; k < 20 && (busy || sb_q.size() != 0); k++) begin
            @(negedge clk);
            #4;
        end
        n_checks++;
        if (busy !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstx_drain busy=%b pending=%0d exp 0/0", busy, sb_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            ta[i] = 64'd0;
            tb[i] = 64'd0;
            ts[i] = 5'd0;
        end
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reject();
        test_wrap_mul();
        test_reset_mid_exec();
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
